// File: rtl/datapath_ctrl_fsm.sv
// Multi-cycle Moore controller sequencing register reads, ALU execute and writeback for the 16-bit datapath.
// Optional macro ILLEGAL_TRAP_EN: unsupported opcodes lock the controller in TRAP (err=1) until reset.
module datapath_ctrl_fsm #(
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [IW-1:0] in,
    output logic          w,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    vsel,
    output logic          write,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [15:0]   sximm8,
    output logic          err
);

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_WR_REG, S_TRAP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_WR_REG
    } state_t;
`endif

    state_t         state_reg, state_next;
    logic [IW-1:0]  ir_reg;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_WAIT;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            // IR is frozen for the whole instruction; only an accepted start reloads it.
            if (state_reg == S_WAIT && s)
                ir_reg <= in;
        end
    end

    assign opcode = ir_reg[15:13];
    assign op     = ir_reg[12:11];
    assign rn     = ir_reg[10:8];
    assign rd     = ir_reg[7:5];
    assign rm     = ir_reg[2:0];
    assign shift  = ir_reg[4:3];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    assign sximm8[7:0] = ir_reg[7:0];
    genvar gi;
    generate
        for (gi = 8; gi < 16; gi++) begin : g_sext
            assign sximm8[gi] = ir_reg[7];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_WAIT:   if (s) state_next = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)
                    state_next = S_WR_IMM;
                else if (is_mov_reg || is_mvn)
                    state_next = S_GET_B;
                else if (is_alu)
                    state_next = S_GET_A;
                else
`ifdef ILLEGAL_TRAP_EN
                    state_next = S_TRAP;
`else
                    state_next = S_WAIT;
`endif
            end
            S_WR_IMM: state_next = S_WAIT;
            S_GET_A:  state_next = S_GET_B;
            S_GET_B:  state_next = S_EXEC;
            S_EXEC:   state_next = is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: state_next = S_WAIT;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   state_next = S_TRAP;
`endif
            default:  state_next = S_WAIT;
        endcase
    end

    // Moore outputs: everything below depends on state_reg and ir_reg only.
    always_comb begin
        w        = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'b00;
        write    = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        ALUop    = 2'b00;
        case (state_reg)
            S_WAIT:   w = 1'b1;
            S_WR_IMM: begin
                vsel     = 2'b10;
                write    = 1'b1;
                writenum = rn;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                // MOV reg runs as 0 + shifted B through the adder.
                ALUop = is_alu ? op : 2'b00;
                asel  = is_mov_reg;
                loadc = !is_cmp;
                loads = is_alu;
            end
            S_WR_REG: begin
                vsel     = 2'b00;
                write    = 1'b1;
                writenum = rd;
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign err = (state_reg == S_TRAP);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Scoreboard bench for datapath_ctrl_fsm: directed instructions push hand-computed per-cycle
// control words and latencies; a negedge monitor pops and compares whenever the controller is busy.
module tb_datapath_ctrl_fsm;
    logic        clk = 1'b0;
    logic        reset, s;
    logic [15:0] in;
    logic        w, loada, loadb, loadc, loads, asel, bsel, write, err;
    logic [1:0]  vsel, shift, ALUop;
    logic [2:0]  readnum, writenum;
    logic [15:0] sximm8;

    datapath_ctrl_fsm #(.IW(16)) dut (
        .clk(clk), .reset(reset), .s(s), .in(in), .w(w),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
        .readnum(readnum), .writenum(writenum), .shift(shift),
        .ALUop(ALUop), .sximm8(sximm8), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [36:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   irz_q[$];
    logic mon_en = 1'b0;
    logic done   = 1'b0;

    localparam int NT = 11;  // TRAP cycles observed before reset

    // Busy-cycle control word {w,loada,loadb,loadc,loads,asel,bsel,vsel,write,readnum,writenum,shift,ALUop,sximm8,err}
    function automatic logic [36:0] cv(input logic la, lb, lc, ls, as, input logic [1:0] vs,
                                       input logic wr, input logic [2:0] rn, wn,
                                       input logic [1:0] sh, alu, input logic [15:0] imm,
                                       input logic er);
        return {1'b0, la, lb, lc, ls, as, 1'b0, vs, wr, rn, wn, sh, alu, imm, er};
    endfunction

    task automatic push_exp(input string nm, input logic [36:0] v);
        exp_t e;
        e.name = nm;
        e.v    = v;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 with the DUT back in WAIT (or bound expired).
    task automatic wait_idle();
        for (int i = 0; i < 40 && !w; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [15:0] instr);
        in = instr;
        s  = 1'b1;
        @(posedge clk);
        #1 s = 1'b0;
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        s     = 1'b0;
        in    = 16'h0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        irz_q.push_back(1);
        @(posedge clk);
        #1;

        // MOV R2,#7
        push_exp("d207_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'h0007,0));
        push_exp("d207_wr_imm", cv(0,0,0,0,0,2'b10,1,3'd0,3'd2,2'b00,2'b00,16'h0007,0));
        lat_q.push_back(3);
        issue(16'hD207);

        // MOV R4,#-128
        push_exp("d480_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'hFF80,0));
        push_exp("d480_wr_imm", cv(0,0,0,0,0,2'b10,1,3'd0,3'd4,2'b00,2'b00,16'hFF80,0));
        lat_q.push_back(3);
        issue(16'hD480);

        // ADD R5,R0,R1 LSL1
        push_exp("a0a9_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b01,2'b00,16'hFFA9,0));
        push_exp("a0a9_get_a",  cv(1,0,0,0,0,2'b00,0,3'd0,3'd0,2'b01,2'b00,16'hFFA9,0));
        push_exp("a0a9_get_b",  cv(0,1,0,0,0,2'b00,0,3'd1,3'd0,2'b01,2'b00,16'hFFA9,0));
        push_exp("a0a9_exec",   cv(0,0,1,1,0,2'b00,0,3'd0,3'd0,2'b01,2'b00,16'hFFA9,0));
        push_exp("a0a9_wr_reg", cv(0,0,0,0,0,2'b00,1,3'd0,3'd5,2'b01,2'b00,16'hFFA9,0));
        lat_q.push_back(6);
        issue(16'hA0A9);

        // CMP R1,R2: no writeback
        push_exp("a902_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'h0002,0));
        push_exp("a902_get_a",  cv(1,0,0,0,0,2'b00,0,3'd1,3'd0,2'b00,2'b00,16'h0002,0));
        push_exp("a902_get_b",  cv(0,1,0,0,0,2'b00,0,3'd2,3'd0,2'b00,2'b00,16'h0002,0));
        push_exp("a902_exec",   cv(0,0,0,1,0,2'b00,0,3'd0,3'd0,2'b00,2'b01,16'h0002,0));
        lat_q.push_back(5);
        issue(16'hA902);

        // MOV R7,R3
        push_exp("c0e3_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'hFFE3,0));
        push_exp("c0e3_get_b",  cv(0,1,0,0,0,2'b00,0,3'd3,3'd0,2'b00,2'b00,16'hFFE3,0));
        push_exp("c0e3_exec",   cv(0,0,1,0,1,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'hFFE3,0));
        push_exp("c0e3_wr_reg", cv(0,0,0,0,0,2'b00,1,3'd0,3'd7,2'b00,2'b00,16'hFFE3,0));
        lat_q.push_back(5);
        issue(16'hC0E3);

        // MVN R6,R1
        push_exp("b8c1_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'hFFC1,0));
        push_exp("b8c1_get_b",  cv(0,1,0,0,0,2'b00,0,3'd1,3'd0,2'b00,2'b00,16'hFFC1,0));
        push_exp("b8c1_exec",   cv(0,0,1,1,0,2'b00,0,3'd0,3'd0,2'b00,2'b11,16'hFFC1,0));
        push_exp("b8c1_wr_reg", cv(0,0,0,0,0,2'b00,1,3'd0,3'd6,2'b00,2'b00,16'hFFC1,0));
        lat_q.push_back(5);
        issue(16'hB8C1);

        // AND R6,R2,R0 LSL1
        push_exp("b2c8_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b01,2'b00,16'hFFC8,0));
        push_exp("b2c8_get_a",  cv(1,0,0,0,0,2'b00,0,3'd2,3'd0,2'b01,2'b00,16'hFFC8,0));
        push_exp("b2c8_get_b",  cv(0,1,0,0,0,2'b00,0,3'd0,3'd0,2'b01,2'b00,16'hFFC8,0));
        push_exp("b2c8_exec",   cv(0,0,1,1,0,2'b00,0,3'd0,3'd0,2'b01,2'b10,16'hFFC8,0));
        push_exp("b2c8_wr_reg", cv(0,0,0,0,0,2'b00,1,3'd0,3'd6,2'b01,2'b00,16'hFFC8,0));
        lat_q.push_back(6);
        issue(16'hB2C8);

        // s held high: two back-to-back MOV R2,#7 with one idle cycle between
        for (int k = 0; k < 2; k++) begin
            push_exp("b2b_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'h0007,0));
            push_exp("b2b_wr_imm", cv(0,0,0,0,0,2'b10,1,3'd0,3'd2,2'b00,2'b00,16'h0007,0));
            lat_q.push_back(3);
        end
        in = 16'hD207;
        s  = 1'b1;
        @(posedge clk);
        #1 wait_idle();
        @(posedge clk);
        #1 s = 1'b0;
        wait_idle();

        // MOV R7,R3 aborted by reset during EXEC: no write strobe, IR cleared
        push_exp("abort_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'hFFE3,0));
        push_exp("abort_get_b",  cv(0,1,0,0,0,2'b00,0,3'd3,3'd0,2'b00,2'b00,16'hFFE3,0));
        push_exp("abort_exec",   cv(0,0,1,0,1,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'hFFE3,0));
        lat_q.push_back(4);
        in = 16'hC0E3;
        s  = 1'b1;
        @(posedge clk);
        #1 s = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        irz_q.push_back(1);
        @(posedge clk);
        #1;

        // Unsupported 110/01 encoding
        push_exp("c800_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'h0000,0));
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < NT; k++)
            push_exp("c800_trap", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'h0000,1));
        lat_q.push_back(NT + 2);
        in = 16'hC800;
        s  = 1'b1;
        @(posedge clk);
        #1 s = 1'b0;
        for (int k = 0; k < NT; k++) begin
            @(posedge clk);
            #1 s = k[0];
        end
        s     = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
`else
        lat_q.push_back(2);
        issue(16'hC800);
`endif

        // Illegal opcode 111
        push_exp("e000_decode", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'h0000,0));
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < NT; k++)
            push_exp("e000_trap", cv(0,0,0,0,0,2'b00,0,3'd0,3'd0,2'b00,2'b00,16'h0000,1));
        lat_q.push_back(NT + 2);
        in = 16'hE000;
        s  = 1'b1;
        @(posedge clk);
        #1 s = 1'b0;
        for (int k = 0; k < NT; k++) begin
            @(posedge clk);
            #1 s = ~k[0];
        end
        s     = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
`else
        lat_q.push_back(2);
        issue(16'hE000);
`endif

        repeat (3) @(posedge clk);
        #1 done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    int          busy     = 0;
    int          cyc      = 0;
    int          lat_want;
    logic [36:0] act;
    exp_t        e;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 5000) begin
                checks++;
                failures++;
                $display("FAIL watchdog cycles=%0d limit=5000", cyc);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (mon_en) begin
                act = {w, loada, loadb, loadc, loads, asel, bsel, vsel, write,
                       readnum, writenum, shift, ALUop, sximm8, err};
                if (!w) begin
                    busy++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_busy got=%h want=<idle>", act);
                    end else begin
                        e = exp_q.pop_front();
                        if (act !== e.v) begin
                            failures++;
                            $display("FAIL %s got=%h want=%h", e.name, act, e.v);
                        end
                    end
                end else begin
                    if (busy > 0) begin
                        checks++;
                        if (lat_q.size() == 0) begin
                            failures++;
                            $display("FAIL latency got=%0d want=<none>", busy + 1);
                        end else begin
                            lat_want = lat_q.pop_front();
                            if (busy + 1 != lat_want) begin
                                failures++;
                                $display("FAIL latency got=%0d want=%0d", busy + 1, lat_want);
                            end
                        end
                        busy = 0;
                    end
                    checks++;
                    if ({loada, loadb, loadc, loads, asel, bsel, vsel, write,
                         readnum, writenum, ALUop, err} !== 17'h0) begin
                        failures++;
                        $display("FAIL idle_outputs got=%h want=0", act);
                    end
                    if (irz_q.size() > 0) begin
                        void'(irz_q.pop_front());
                        checks++;
                        if ({sximm8, shift} !== 18'h0) begin
                            failures++;
                            $display("FAIL ir_after_reset sximm8=%h shift=%b want=0000/00", sximm8, shift);
                        end
                    end
                end
                if (done) begin
                    checks++;
                    if (exp_q.size() != 0 || lat_q.size() != 0) begin
                        failures++;
                        $display("FAIL leftover_expect words=%0d latencies=%0d want=0/0",
                                 exp_q.size(), lat_q.size());
                    end
                    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                    $finish;
                end
            end
        end
    end
endmodule
